// File: rtl/buzzer_beep_ctrl.sv
// Beep sequencer: turns one-cycle event pulses into gated square-wave
// buzzer patterns with a one-deep request queue.
module buzzer_beep_ctrl #(
    parameter int TONE_HALF_CYC = 25000,
    parameter int BEEP_CYC      = 10000000,
    parameter int GAP_CYC       = 5000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       beep_pulse,
    input  logic [1:0] beep_count,
    output logic       buzzer,
    output logic       busy,
    output logic       done,
    output logic       dropped
);

    localparam int HW = (TONE_HALF_CYC > 1) ? $clog2(TONE_HALF_CYC) : 1;
    localparam int TW = (BEEP_CYC > 1) ? $clog2(BEEP_CYC) : 1;
    localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    localparam logic [HW-1:0] HALF_LAST = HW'(TONE_HALF_CYC - 1);
    localparam logic [TW-1:0] TONE_LAST = TW'(BEEP_CYC - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYC - 1);

    typedef enum logic [1:0] {
        IDLE,
        TONE,
        GAP
    } state_e;

    state_e        state_q, state_d;
    logic [1:0]    rem_q, rem_d;
    logic          pend_vld_q, pend_vld_d;
    logic [1:0]    pend_cnt_q, pend_cnt_d;
    logic [HW-1:0] half_q, half_d;
    logic [TW-1:0] tone_q, tone_d;
    logic [GW-1:0] gap_q, gap_d;
    logic          buzzer_q, buzzer_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          dropped_q, dropped_d;
    logic [1:0]    req_cnt;

    assign req_cnt = (beep_count == 2'd0) ? 2'd1 : beep_count;

    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        pend_vld_d = pend_vld_q;
        pend_cnt_d = pend_cnt_q;
        half_d     = half_q;
        tone_d     = tone_q;
        gap_d      = gap_q;
        buzzer_d   = buzzer_q;
        done_d     = 1'b0;
        dropped_d  = 1'b0;

        // Busy-time requests land in the slot first, so a pulse on the
        // final tone cycle is seen by the end-of-sequence logic below.
        if (beep_pulse && state_q != IDLE) begin
            if (pend_vld_q) begin
                dropped_d = 1'b1;
            end else begin
                pend_vld_d = 1'b1;
                pend_cnt_d = req_cnt;
            end
        end

        unique case (state_q)
            IDLE: begin
                if (beep_pulse) begin
                    rem_d    = req_cnt;
                    state_d  = TONE;
                    tone_d   = '0;
                    half_d   = '0;
                    buzzer_d = 1'b1;
                end
            end
            TONE: begin
                if (half_q == HALF_LAST) begin
                    half_d   = '0;
                    buzzer_d = ~buzzer_q;
                end else begin
                    half_d = half_q + 1'b1;
                end
                tone_d = tone_q + 1'b1;
                if (tone_q == TONE_LAST) begin
                    buzzer_d = 1'b0;
                    tone_d   = '0;
                    gap_d    = '0;
                    if (rem_q != 2'd1) begin
                        rem_d   = rem_q - 2'd1;
                        state_d = GAP;
                    end else begin
                        done_d = 1'b1;
                        if (pend_vld_d) begin
                            rem_d      = pend_cnt_d;
                            pend_vld_d = 1'b0;
                            state_d    = GAP;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            GAP: begin
                gap_d = gap_q + 1'b1;
                if (gap_q == GAP_LAST) begin
                    gap_d    = '0;
                    state_d  = TONE;
                    tone_d   = '0;
                    half_d   = '0;
                    buzzer_d = 1'b1;
                end
            end
            default: begin
                state_d  = IDLE;
                buzzer_d = 1'b0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rem_q      <= '0;
            pend_vld_q <= 1'b0;
            pend_cnt_q <= '0;
            half_q     <= '0;
            tone_q     <= '0;
            gap_q      <= '0;
            buzzer_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            dropped_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rem_q      <= rem_d;
            pend_vld_q <= pend_vld_d;
            pend_cnt_q <= pend_cnt_d;
            half_q     <= half_d;
            tone_q     <= tone_d;
            gap_q      <= gap_d;
            buzzer_q   <= buzzer_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            dropped_q  <= dropped_d;
        end
    end

    assign buzzer  = buzzer_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign dropped = dropped_q;

endmodule

// File: tb/tb_buzzer_beep_ctrl.sv
// Directed bench for buzzer_beep_ctrl with short tone/beep/gap timing.
// Bit n of each captured vector is the output seen in cycle n.
module tb_buzzer_beep_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       beep_pulse = 1'b0;
    logic [1:0] beep_count = 2'd0;
    logic       buzzer, busy, done, dropped;

    int tests = 0;
    int fails = 0;

    int sched_cyc [3];
    int sched_cnt [3];
    logic [63:0] cap_buz, cap_busy, cap_done, cap_drop;

    buzzer_beep_ctrl #(
        .TONE_HALF_CYC(2),
        .BEEP_CYC     (10),
        .GAP_CYC      (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .beep_pulse(beep_pulse),
        .beep_count(beep_count),
        .buzzer    (buzzer),
        .busy      (busy),
        .done      (done),
        .dropped   (dropped)
    );

    always #5 clk = ~clk;

    // 10-cycle tone window starting at s: pattern 1,1,0,0,1,1,0,0,1,1
    function automatic logic [63:0] tone(input int s);
        logic [63:0] m = '0;
        for (int i = 0; i < 10; i++)
            if (((i / 2) % 2) == 0) m |= 64'd1 << (s + i);
        return m;
    endfunction

    function automatic logic [63:0] win(input int s, input int e);
        logic [63:0] m = '0;
        for (int i = s; i <= e; i++) m |= 64'd1 << i;
        return m;
    endfunction

    function automatic logic [63:0] bitv(input int n);
        return 64'd1 << n;
    endfunction

    task automatic set_sched(input int c0, input int n0, input int c1,
                             input int n1, input int c2, input int n2);
        sched_cyc[0] = c0; sched_cnt[0] = n0;
        sched_cyc[1] = c1; sched_cnt[1] = n1;
        sched_cyc[2] = c2; sched_cnt[2] = n2;
    endtask

    task automatic run(input int ncyc);
        cap_buz = '0; cap_busy = '0; cap_done = '0; cap_drop = '0;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            cap_buz[c]  = buzzer;
            cap_busy[c] = busy;
            cap_done[c] = done;
            cap_drop[c] = dropped;
            beep_pulse = 1'b0;
            beep_count = 2'd0;
            for (int k = 0; k < 3; k++)
                if (sched_cyc[k] == c) begin
                    beep_pulse = 1'b1;
                    beep_count = 2'(sched_cnt[k]);
                end
        end
        beep_pulse = 1'b0;
        beep_count = 2'd0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests++;
        if ({buzzer, busy, done, dropped} !== 4'b0000) begin
            fails++;
            $display("FAIL reset_outputs got %b want 0000",
                     {buzzer, busy, done, dropped});
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single(input string nm, input int cnt);
        set_sched(0, cnt, -1, 0, -1, 0);
        run(15);
        tests++;
        if (cap_buz !== tone(1)) begin
            fails++;
            $display("FAIL %s_buz got %h want %h", nm, cap_buz, tone(1));
        end
        tests++;
        if (cap_busy !== win(1, 10)) begin
            fails++;
            $display("FAIL %s_busy got %h want %h", nm, cap_busy, win(1, 10));
        end
        tests++;
        if (cap_done !== bitv(11)) begin
            fails++;
            $display("FAIL %s_done got %h want %h", nm, cap_done, bitv(11));
        end
        tests++;
        if (cap_drop !== 64'd0) begin
            fails++;
            $display("FAIL %s_drop got %h want 0", nm, cap_drop);
        end
    endtask

    task automatic test_count3;
        logic [63:0] eb;
        eb = tone(1) | tone(15) | tone(29);
        set_sched(0, 3, -1, 0, -1, 0);
        run(43);
        tests++;
        if (cap_buz !== eb) begin
            fails++;
            $display("FAIL c3_buz got %h want %h", cap_buz, eb);
        end
        tests++;
        if (cap_busy !== win(1, 38)) begin
            fails++;
            $display("FAIL c3_busy got %h want %h", cap_busy, win(1, 38));
        end
        tests++;
        if (cap_done !== bitv(39)) begin
            fails++;
            $display("FAIL c3_done got %h want %h", cap_done, bitv(39));
        end
    endtask

    task automatic test_queue_drop;
        logic [63:0] eb, ed;
        eb = tone(1) | tone(15) | tone(29);
        ed = bitv(11) | bitv(39);
        set_sched(0, 1, 5, 2, 6, 3);
        run(43);
        tests++;
        if (cap_buz !== eb) begin
            fails++;
            $display("FAIL queue_buz got %h want %h", cap_buz, eb);
        end
        tests++;
        if (cap_busy !== win(1, 38)) begin
            fails++;
            $display("FAIL queue_busy got %h want %h", cap_busy, win(1, 38));
        end
        tests++;
        if (cap_done !== ed) begin
            fails++;
            $display("FAIL queue_done got %h want %h", cap_done, ed);
        end
        tests++;
        if (cap_drop !== bitv(7)) begin
            fails++;
            $display("FAIL queue_drop got %h want %h", cap_drop, bitv(7));
        end
    endtask

    task automatic test_boundary;
        logic [63:0] eb, ed;
        eb = tone(1) | tone(15);
        ed = bitv(11) | bitv(25);
        set_sched(0, 1, 10, 1, -1, 0);
        run(28);
        tests++;
        if (cap_buz !== eb) begin
            fails++;
            $display("FAIL bound_buz got %h want %h", cap_buz, eb);
        end
        tests++;
        if (cap_busy !== win(1, 24)) begin
            fails++;
            $display("FAIL bound_busy got %h want %h", cap_busy, win(1, 24));
        end
        tests++;
        if (cap_done !== ed) begin
            fails++;
            $display("FAIL bound_done got %h want %h", cap_done, ed);
        end
        tests++;
        if (cap_drop !== 64'd0) begin
            fails++;
            $display("FAIL bound_drop got %h want 0", cap_drop);
        end
    endtask

    task automatic test_back_to_back;
        logic [63:0] eb, ebu, ed;
        eb  = tone(1) | tone(12);
        ebu = win(1, 10) | win(12, 21);
        ed  = bitv(11) | bitv(22);
        set_sched(0, 1, 11, 1, -1, 0);
        run(25);
        tests++;
        if (cap_buz !== eb) begin
            fails++;
            $display("FAIL b2b_buz got %h want %h", cap_buz, eb);
        end
        tests++;
        if (cap_busy !== ebu) begin
            fails++;
            $display("FAIL b2b_busy got %h want %h", cap_busy, ebu);
        end
        tests++;
        if (cap_done !== ed) begin
            fails++;
            $display("FAIL b2b_done got %h want %h", cap_done, ed);
        end
    endtask

    task automatic test_mid_reset;
        // count=1 at cycle 0, queued count=2 at cycle 2, reset in cycle 5
        for (int c = 0; c <= 5; c++) begin
            @(negedge clk);
            beep_pulse = (c == 0) || (c == 2);
            beep_count = (c == 2) ? 2'd2 : 2'd1;
        end
        beep_pulse = 1'b0;
        tests++;
        if ({buzzer, busy} !== 2'b11) begin
            fails++;
            $display("FAIL mid_pre got %b want 11", {buzzer, busy});
        end
        rst_n = 1'b0;
        #1;
        tests++;
        if ({buzzer, busy, done, dropped} !== 4'b0000) begin
            fails++;
            $display("FAIL mid_async got %b want 0000",
                     {buzzer, busy, done, dropped});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        set_sched(-1, 0, -1, 0, -1, 0);
        run(20);
        tests++;
        if ((cap_buz | cap_busy | cap_done | cap_drop) !== 64'd0) begin
            fails++;
            $display("FAIL mid_idle got %h want 0",
                     cap_buz | cap_busy | cap_done | cap_drop);
        end
        test_single("post_rst", 1);
    endtask

    initial begin
        test_reset();
        test_single("single", 1);
        test_single("count0", 0);
        test_count3();
        test_queue_drop();
        test_boundary();
        test_back_to_back();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
